// File: rtl/draw_pkg.sv
// Shared types and default geometry for the rectangle plotter.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;
  localparam int DEF_X_W      = 9;
  localparam int DEF_Y_W      = 8;
  localparam int DEF_COL_W    = 3;
  localparam int DEF_SZ_W     = 7;
  localparam int DEF_MAX_W    = 64;
  localparam int DEF_MAX_H    = 64;

endpackage

// File: rtl/raster_counter.sv
// Column/row walker over a W x H box, row-major, with optional interior skip
// so outline mode jumps straight from column 0 to column W-1.
module raster_counter #(
  parameter int SZ_W = draw_pkg::DEF_SZ_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            enable,
  input  logic            skip,
  input  logic [SZ_W-1:0] width,
  input  logic [SZ_W-1:0] height,
  output logic [SZ_W-1:0] col_next,
  output logic [SZ_W-1:0] row_next,
  output logic            last
);

  localparam logic [SZ_W-1:0] ONE = SZ_W'(1);

  logic [SZ_W-1:0] col_reg;
  logic [SZ_W-1:0] row_reg;
  logic [SZ_W-1:0] w_m1;
  logic [SZ_W-1:0] h_m1;
  logic            end_col;
  logic            interior;

  assign w_m1     = width - ONE;
  assign h_m1     = height - ONE;
  assign end_col  = (col_reg == w_m1);
  assign interior = (row_reg != '0) && (row_reg != h_m1);
  assign last     = end_col && (row_reg == h_m1);

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (enable) begin
      if (end_col) begin
        col_next = '0;
        row_next = row_reg + ONE;
      end else if (skip && interior && (col_reg == '0)) begin
        col_next = w_m1;
      end else begin
        col_next = col_reg + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (clear) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Filled (or, with RECT_OUTLINE_EN defined, optionally outlined) box rasteriser
// emitting one registered pixel per cycle with screen clipping on oPlot.
module rect_plotter
  import draw_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COL_W    = DEF_COL_W,
  parameter int SZ_W     = DEF_SZ_W,
  parameter int MAX_W    = DEF_MAX_W,
  parameter int MAX_H    = DEF_MAX_H,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             iPlotBox,
  input  logic [X_W-1:0]   iStart_X,
  input  logic [Y_W-1:0]   iStart_Y,
  input  logic [SZ_W-1:0]  iWidth,
  input  logic [SZ_W-1:0]  iHeight,
  input  logic [COL_W-1:0] iColour,
  output logic [X_W-1:0]   oX,
  output logic [Y_W-1:0]   oY,
  output logic [COL_W-1:0] oColour,
  output logic             oPlot,
  output logic             oBusy,
  output logic             oDone
`ifdef RECT_OUTLINE_EN
  ,
  input  logic             iOutline
`endif
);

  localparam logic [SZ_W-1:0] MAX_W_L  = SZ_W'(MAX_W);
  localparam logic [SZ_W-1:0] MAX_H_L  = SZ_W'(MAX_H);
  localparam logic [X_W:0]    SCR_W_L  = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]    SCR_H_L  = (Y_W+1)'(SCREEN_H);

  state_t           state_reg, state_next;
  logic [X_W-1:0]   start_x_reg;
  logic [Y_W-1:0]   start_y_reg;
  logic [SZ_W-1:0]  w_reg, h_reg;
  logic             outline_reg;
  logic [X_W-1:0]   ox_reg;
  logic [Y_W-1:0]   oy_reg;
  logic [COL_W-1:0] ocol_reg;
  logic             plot_reg;

  logic             size_zero;
  logic [SZ_W-1:0]  w_clamp, h_clamp;
  logic [SZ_W-1:0]  col_next, row_next;
  logic             last;
  logic [X_W-1:0]   px_x;
  logic [Y_W-1:0]   px_y;

  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return ({1'b0, x} < SCR_W_L) && ({1'b0, y} < SCR_H_L);
  endfunction

  assign size_zero = (iWidth == '0) || (iHeight == '0);
  assign w_clamp   = (iWidth  > MAX_W_L) ? MAX_W_L : iWidth;
  assign h_clamp   = (iHeight > MAX_H_L) ? MAX_H_L : iHeight;

  // Coordinates wrap naturally at the register width.
  assign px_x = start_x_reg + X_W'(col_next);
  assign px_y = start_y_reg + Y_W'(row_next);

  raster_counter #(.SZ_W(SZ_W)) u_raster (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state_reg == IDLE),
    .enable   ((state_reg == DRAW) && !last),
    .skip     (outline_reg),
    .width    (w_reg),
    .height   (h_reg),
    .col_next (col_next),
    .row_next (row_next),
    .last     (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (iPlotBox) state_next = size_zero ? DONE : DRAW;
      DRAW:    if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_x_reg <= '0;
      start_y_reg <= '0;
      w_reg       <= '0;
      h_reg       <= '0;
      ox_reg      <= '0;
      oy_reg      <= '0;
      ocol_reg    <= '0;
      plot_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (iPlotBox) begin
            start_x_reg <= iStart_X;
            start_y_reg <= iStart_Y;
            w_reg       <= w_clamp;
            h_reg       <= h_clamp;
            ox_reg      <= iStart_X;
            oy_reg      <= iStart_Y;
            ocol_reg    <= iColour;
            plot_reg    <= !size_zero && on_screen(iStart_X, iStart_Y);
          end
        end
        DRAW: begin
          if (last) begin
            plot_reg <= 1'b0;
          end else begin
            ox_reg   <= px_x;
            oy_reg   <= px_y;
            plot_reg <= on_screen(px_x, px_y);
          end
        end
        default: plot_reg <= 1'b0;
      endcase
    end
  end

`ifdef RECT_OUTLINE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          outline_reg <= 1'b0;
    else if ((state_reg == IDLE) && iPlotBox) outline_reg <= iOutline;
  end
`else
  assign outline_reg = 1'b0;
`endif

  assign oX      = ox_reg;
  assign oY      = oy_reg;
  assign oColour = ocol_reg;
  assign oPlot   = plot_reg;
  assign oBusy   = (state_reg != IDLE);
  assign oDone   = (state_reg == DONE);

endmodule
